// File: rtl/triangle_setup_if.sv
// Triangle setup handshake bundle: vertex input stream and setup-record output stream.
interface triangle_setup_if;
    logic [287:0] vertex_data;
    logic         vertex_data_valid;
    logic         vertex_data_ready;
    logic         setup_valid;
    logic         setup_ready;
    logic [47:0]  bbox;
    logic [38:0]  edge_a;
    logic [38:0]  edge_b;
    logic [74:0]  edge_c;
    logic [25:0]  area2;
    logic [95:0]  colors;

    modport master (
        output vertex_data, vertex_data_valid, setup_ready,
        input  vertex_data_ready, setup_valid, bbox, edge_a, edge_b, edge_c, area2, colors
    );

    modport slave (
        input  vertex_data, vertex_data_valid, setup_ready,
        output vertex_data_ready, setup_valid, bbox, edge_a, edge_b, edge_c, area2, colors
    );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: edge equations, bounding box, doubled area, orientation fix-up,
// window clipping/culling, using one shared 12x12 multiplier.
module triangle_setup (
    input  logic            clock,
    input  logic            reset,
    input  logic [11:0]     win_width,
    input  logic [11:0]     win_height,
    output logic [15:0]     culled_count,
    output logic [3:0]      state,
    triangle_setup_if.slave bus
);
    localparam int unsigned CW = 12;
    localparam int unsigned EW = 13;
    localparam int unsigned PW = 24;
    localparam int unsigned KW = 25;
    localparam int unsigned AW = 26;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_EDGE = 4'd1, S_MUL = 4'd2,
        S_AREA = 4'd3, S_ORIENT = 4'd4, S_OUT = 4'd5
    } state_t;

    state_t cur, nxt;
    logic   accept_c, load_edge_c, mul_en_c, load_area_c, emit_c, drop_c, cull_c;

    logic [CW-1:0]        vx [3];
    logic [CW-1:0]        vy [3];
    logic [95:0]          col_r;
    logic [CW-1:0]        ww_r, wh_r;
    logic signed [EW-1:0] a_r [3];
    logic signed [EW-1:0] b_r [3];
    logic signed [KW-1:0] c_r [3];
    logic signed [AW-1:0] area_r;
    logic [CW-1:0]        bb_min_x, bb_max_x, bb_min_y, bb_max_y;
    logic [2:0]           mul_cnt;
    logic [PW-1:0]        prod_hold, prod;
    logic [CW-1:0]        mul_x, mul_y, clamp_x, clamp_y;
    logic                 flip;

    // Only x/y fields of each vertex word carry data
    logic unused_vertex_bits;
    assign unused_vertex_bits = ^{bus.vertex_data[275:256], bus.vertex_data[243:224],
                                  bus.vertex_data[211:192], bus.vertex_data[179:160],
                                  bus.vertex_data[147:128], bus.vertex_data[115:96]};

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] p, q, r);
        logic [CW-1:0] m;
        m = (p < q) ? p : q;
        return (r < m) ? r : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] p, q, r);
        logic [CW-1:0] m;
        m = (p > q) ? p : q;
        return (r > m) ? r : m;
    endfunction

    function automatic logic [EW-1:0] neg13(input logic signed [EW-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [KW-1:0] neg25(input logic signed [KW-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) cur <= S_IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   if (bus.vertex_data_valid) nxt = S_EDGE;
            S_EDGE:   nxt = S_MUL;
            S_MUL:    if (mul_cnt == 3'd5) nxt = S_AREA;
            S_AREA:   nxt = S_ORIENT;
            S_ORIENT: nxt = cull_c ? S_IDLE : S_OUT;
            S_OUT:    if (bus.setup_ready) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept_c    = 1'b0;
        load_edge_c = 1'b0;
        mul_en_c    = 1'b0;
        load_area_c = 1'b0;
        emit_c      = 1'b0;
        drop_c      = 1'b0;
        case (cur)
            S_IDLE:   accept_c    = bus.vertex_data_valid;
            S_EDGE:   load_edge_c = 1'b1;
            S_MUL:    mul_en_c    = 1'b1;
            S_AREA:   load_area_c = 1'b1;
            S_ORIENT: begin
                emit_c = ~cull_c;
                drop_c = cull_c;
            end
            default: ;
        endcase
    end

    assign state = cur;

    // Product schedule: pairs (x_i*y_j, x_j*y_i) for edges 0,1,2
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (mul_cnt)
            3'd0: begin mul_x = vx[0]; mul_y = vy[1]; end
            3'd1: begin mul_x = vx[1]; mul_y = vy[0]; end
            3'd2: begin mul_x = vx[1]; mul_y = vy[2]; end
            3'd3: begin mul_x = vx[2]; mul_y = vy[1]; end
            3'd4: begin mul_x = vx[2]; mul_y = vy[0]; end
            3'd5: begin mul_x = vx[0]; mul_y = vy[2]; end
            default: ;
        endcase
    end
    assign prod = PW'(mul_x) * PW'(mul_y);

    assign cull_c  = (area_r == '0) || (bb_min_x >= ww_r) || (bb_min_y >= wh_r) ||
                     (ww_r == '0) || (wh_r == '0);
    assign clamp_x = (bb_max_x >= ww_r) ? ww_r - 12'd1 : bb_max_x;
    assign clamp_y = (bb_max_y >= wh_r) ? wh_r - 12'd1 : bb_max_y;
    assign flip    = area_r[AW-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                vx[i]  <= '0;
                vy[i]  <= '0;
                a_r[i] <= '0;
                b_r[i] <= '0;
                c_r[i] <= '0;
            end
            col_r        <= '0;
            ww_r         <= '0;
            wh_r         <= '0;
            area_r       <= '0;
            bb_min_x     <= '0;
            bb_max_x     <= '0;
            bb_min_y     <= '0;
            bb_max_y     <= '0;
            mul_cnt      <= '0;
            prod_hold    <= '0;
            culled_count <= '0;
            bus.bbox     <= '0;
            bus.edge_a   <= '0;
            bus.edge_b   <= '0;
            bus.edge_c   <= '0;
            bus.area2    <= '0;
            bus.colors   <= '0;
        end else begin
            if (accept_c) begin
                vx[0] <= bus.vertex_data[287:276];
                vy[0] <= bus.vertex_data[255:244];
                vx[1] <= bus.vertex_data[223:212];
                vy[1] <= bus.vertex_data[191:180];
                vx[2] <= bus.vertex_data[159:148];
                vy[2] <= bus.vertex_data[127:116];
                col_r <= bus.vertex_data[95:0];
                ww_r  <= win_width;
                wh_r  <= win_height;
            end
            if (load_edge_c) begin
                a_r[0]   <= {1'b0, vy[0]} - {1'b0, vy[1]};
                a_r[1]   <= {1'b0, vy[1]} - {1'b0, vy[2]};
                a_r[2]   <= {1'b0, vy[2]} - {1'b0, vy[0]};
                b_r[0]   <= {1'b0, vx[1]} - {1'b0, vx[0]};
                b_r[1]   <= {1'b0, vx[2]} - {1'b0, vx[1]};
                b_r[2]   <= {1'b0, vx[0]} - {1'b0, vx[2]};
                bb_min_x <= min3(vx[0], vx[1], vx[2]);
                bb_max_x <= max3(vx[0], vx[1], vx[2]);
                bb_min_y <= min3(vy[0], vy[1], vy[2]);
                bb_max_y <= max3(vy[0], vy[1], vy[2]);
                mul_cnt  <= '0;
            end
            // Even step holds the first product, odd step forms c_i
            if (mul_en_c) begin
                mul_cnt <= mul_cnt + 3'd1;
                if (!mul_cnt[0]) prod_hold <= prod;
                else             c_r[mul_cnt[2:1]] <= KW'(prod_hold) - KW'(prod);
            end
            if (load_area_c)
                area_r <= {c_r[0][KW-1], c_r[0]} + {c_r[1][KW-1], c_r[1]} + {c_r[2][KW-1], c_r[2]};
            if (emit_c) begin
                bus.bbox   <= {bb_min_x, clamp_x, bb_min_y, clamp_y};
                bus.edge_a <= {neg13(a_r[0], flip), neg13(a_r[1], flip), neg13(a_r[2], flip)};
                bus.edge_b <= {neg13(b_r[0], flip), neg13(b_r[1], flip), neg13(b_r[2], flip)};
                bus.edge_c <= {neg25(c_r[0], flip), neg25(c_r[1], flip), neg25(c_r[2], flip)};
                bus.area2  <= flip ? -area_r : area_r;
                bus.colors <= col_r;
            end
            if (drop_c && culled_count != 16'hFFFF)
                culled_count <= culled_count + 16'd1;
        end
    end

    // Handshake flags track the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vertex_data_ready <= 1'b1;
            bus.setup_valid       <= 1'b0;
        end else begin
            bus.vertex_data_ready <= (nxt == S_IDLE);
            bus.setup_valid       <= (nxt == S_OUT);
        end
    end
endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: hand-computed setup records, culls, stall and reset.
module tb_triangle_setup;
    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] win_width, win_height;
    logic [15:0] culled_count;
    logic [3:0]  state;

    triangle_setup_if bus();

    triangle_setup dut (
        .clock        (clock),
        .reset        (reset),
        .win_width    (win_width),
        .win_height   (win_height),
        .culled_count (culled_count),
        .state        (state),
        .bus          (bus)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [95:0] C1 = {32'h11111111, 32'h22222222, 32'h33333333};
    localparam logic [95:0] C2 = {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    localparam logic [95:0] C3 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] vtx(input int x, input int y);
        return {12'(x), 20'd0, 12'(y), 20'd0};
    endfunction

    function automatic logic [38:0] p13(input int a, input int b, input int c);
        return {13'(a), 13'(b), 13'(c)};
    endfunction

    function automatic logic [74:0] p25(input int a, input int b, input int c);
        return {25'(a), 25'(b), 25'(c)};
    endfunction

    function automatic logic [47:0] pbb(input int a, input int b, input int c, input int d);
        return {12'(a), 12'(b), 12'(c), 12'(d)};
    endfunction

    // Called at a negedge while IDLE; returns at the negedge after the accept edge
    task automatic drive_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, input logic [95:0] col);
        bus.vertex_data       = {vtx(ax, ay), vtx(bx, by), vtx(cx, cy), col};
        bus.vertex_data_valid = 1'b1;
        @(negedge clock);
        bus.vertex_data_valid = 1'b0;
        bus.vertex_data       = '1;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clock);
            if (bus.setup_valid || state == 4'd0) lat = i;
        end
        check({tag, " latency"}, 96'(lat), 96'(9));
    endtask

    task automatic check_rec(input string tag, input logic [47:0] bb, input logic [38:0] ea,
                             input logic [38:0] eb, input logic [74:0] ec, input int ar,
                             input logic [95:0] col);
        check({tag, " setup_valid"}, 96'(bus.setup_valid), 96'(1));
        check({tag, " bbox"},   96'(bus.bbox),   96'(bb));
        check({tag, " edge_a"}, 96'(bus.edge_a), 96'(ea));
        check({tag, " edge_b"}, 96'(bus.edge_b), 96'(eb));
        check({tag, " edge_c"}, 96'(bus.edge_c), 96'(ec));
        check({tag, " area2"},  96'(bus.area2),  96'(26'(ar)));
        check({tag, " colors"}, bus.colors, col);
    endtask

    task automatic release_rec();
        bus.setup_ready = 1'b1;
        @(negedge clock);
        bus.setup_ready = 1'b0;
    endtask

    task automatic check_cull(input string tag, input int count);
        check({tag, " no valid"}, 96'(bus.setup_valid), 96'(0));
        check({tag, " culled"},   96'(culled_count),    96'(count));
        check({tag, " ready"},    96'(bus.vertex_data_ready), 96'(1));
    endtask

    initial begin
        reset                 = 1'b1;
        bus.vertex_data       = '0;
        bus.vertex_data_valid = 1'b0;
        bus.setup_ready       = 1'b0;
        win_width             = 12'd640;
        win_height            = 12'd480;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("reset state", 96'(state), 96'(0));
        check("reset ready", 96'(bus.vertex_data_ready), 96'(1));
        check("reset valid", 96'(bus.setup_valid), 96'(0));
        check("reset culled", 96'(culled_count), 96'(0));
        check("reset record", 96'({bus.bbox, bus.area2}), 96'(0));

        // Counter-clockwise right triangle, then a 5-cycle stall in OUT
        drive_tri(0, 0, 10, 0, 0, 10, C1);
        check("t1 state edge", 96'(state), 96'(1));
        check("t1 busy", 96'(bus.vertex_data_ready), 96'(0));
        wait_done("t1");
        check_rec("t1", pbb(0, 10, 0, 10), p13(0, -10, 10), p13(10, -10, 0),
                  p25(0, 100, 0), 100, C1);
        bus.vertex_data       = {vtx(1, 2), vtx(3, 4), vtx(5, 6), C3};
        bus.vertex_data_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("t1 stall hold",
                  96'({bus.setup_valid, bus.vertex_data_ready, bus.bbox, bus.area2}),
                  96'({1'b1, 1'b0, pbb(0, 10, 0, 10), 26'd100}));
            check("t1 stall colors", bus.colors, C1);
        end
        bus.setup_ready = 1'b1;
        @(negedge clock);
        bus.setup_ready = 1'b0;
        check("t1 released valid", 96'(bus.setup_valid), 96'(0));
        check("t1 released state", 96'(state), 96'(0));

        // Clockwise triangle accepted on the very next cycle
        drive_tri(0, 0, 0, 10, 10, 0, C2);
        check("t2 state edge", 96'(state), 96'(1));
        wait_done("t2");
        check_rec("t2", pbb(0, 10, 0, 10), p13(10, -10, 0), p13(0, -10, 10),
                  p25(0, 100, 0), 100, C2);
        release_rec();

        // Collinear -> culled
        drive_tri(0, 0, 5, 5, 10, 10, C1);
        wait_done("t3");
        check_cull("t3", 1);
        check("t3 state", 96'(state), 96'(0));

        // Clamp max_x; window changes after accept must not matter
        drive_tri(600, 0, 700, 0, 600, 50, C3);
        win_width  = 12'd100;
        win_height = 12'd7;
        wait_done("t4");
        check_rec("t4", pbb(600, 639, 0, 50), p13(0, -50, 50), p13(100, -100, 0),
                  p25(0, 35000, -30000), 5000, C3);
        win_width  = 12'd640;
        win_height = 12'd480;
        release_rec();

        drive_tri(650, 0, 700, 0, 650, 50, C3);
        wait_done("t5");
        check_cull("t5", 2);

        win_height = 12'd5;
        drive_tri(0, 10, 10, 10, 0, 20, C2);
        wait_done("t6");
        check_cull("t6", 3);

        win_width  = 12'd0;
        win_height = 12'd480;
        drive_tri(0, 0, 10, 0, 0, 10, C1);
        wait_done("t7");
        check_cull("t7", 4);
        win_width = 12'd640;

        // Reset in the third MUL cycle discards the triangle
        drive_tri(0, 0, 10, 0, 0, 10, C1);
        repeat (3) @(negedge clock);
        check("t8 state mul", 96'(state), 96'(2));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t8 state", 96'(state), 96'(0));
        check("t8 ready", 96'(bus.vertex_data_ready), 96'(1));
        check("t8 valid", 96'(bus.setup_valid), 96'(0));
        check("t8 culled", 96'(culled_count), 96'(0));
        check("t8 bbox", 96'(bus.bbox), 96'(0));
        check("t8 edges", 96'({bus.edge_a, bus.edge_b}), 96'(0));
        check("t8 edge_c", 96'(bus.edge_c), 96'(0));
        check("t8 area2", 96'(bus.area2), 96'(0));
        check("t8 colors", bus.colors, 96'(0));

        drive_tri(0, 0, 0, 10, 10, 0, C2);
        wait_done("t9");
        check_rec("t9", pbb(0, 10, 0, 10), p13(10, -10, 0), p13(0, -10, 10),
                  p25(0, 100, 0), 100, C2);
        release_rec();
        check("t9 idle", 96'(state), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
